mmio_input_capture: RTL and testbench

//  Memory-mapped input responder for the single-cycle ARM data bus (the CPU-read side of the peripheral map).

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/input_debouncer.sv | 59 +++++
 rtl/mmio_input_capture.sv | 85 ++++++++
 tb/tb_mmio_input_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped peripheral map and the button
// status register layout.
package mmio_pkg;

  localparam logic [31:0] MMIO_LEDS = 32'hC000_0000;
  localparam logic [31:0] MMIO_SW   = 32'hC000_0004;
  localparam logic [31:0] MMIO_DISP = 32'hC000_0008;
  localparam logic [31:0] MMIO_ABR  = 32'hC000_000C;
  localparam logic [31:0] MMIO_BTN  = 32'hC000_0010;

  localparam int BTN_PENDING_BIT = 0;
  localparam int BTN_LEVEL_BIT   = 1;
  localparam int BTN_CNT_LSB     = 8;

  typedef logic [7:0] press_cnt_t;

  // Assemble the button status word: count in [15:8], level, pending flag.
  function automatic logic [31:0] btn_status_word(input press_cnt_t cnt,
                                                  input logic       level,
                                                  input logic       pending);
    logic [31:0] w;
    w                  = 32'b0;
    w[BTN_CNT_LSB+:8]  = cnt;
    w[BTN_LEVEL_BIT]   = level;
    w[BTN_PENDING_BIT] = pending;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability counter. A new level is
// accepted only after the synchronized input has disagreed with the current
// level for DEBOUNCE_CYCLES consecutive cycles; rise marks the accepting
// edge of a 0->1 change.
module input_debouncer
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             expire;

  assign differ = sync_p1 ^ stable;
  assign expire = differ && (cnt == CNT_LAST);

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (expire) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = stable;
  assign rise  = expire & sync_p1;

endmodule

// File: rtl/mmio_input_capture.sv
// CPU-readable input peripheral: synchronized switches and a debounced
// ENTER button with a sticky, write-1-to-clear press flag and a wrapping
// 8-bit press counter. rd/hit are purely combinational for the read mux.
module mmio_input_capture
  import mmio_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int          NSW             = 10,
  parameter logic [31:0] SW_ADDR         = MMIO_SW,
  parameter logic [31:0] BTN_ADDR        = MMIO_BTN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_raw,
  input  logic [NSW-1:0] sw_raw,
  input  logic [31:0]    a,
  input  logic           we,
  input  logic [31:0]    wd,
  output logic [31:0]    rd,
  output logic           hit
);

  logic           btn_norm;
  logic           btn_level;
  logic           btn_rise;
  logic [NSW-1:0] sw_p0;
  logic [NSW-1:0] sw_p1;
  logic           pending;
  press_cnt_t     press_cnt;
  logic           clr_req;

  // Normalise polarity before synchronizing so 1 always means pressed.
  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_deb (
    .clk  (clk),
    .reset(reset),
    .din  (btn_norm),
    .level(btn_level),
    .rise (btn_rise)
  );

  // Switches are only synchronized; they are read as levels, not events.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw_raw;
      sw_p1 <= sw_p0;
    end
  end

  assign clr_req = we && (a == BTN_ADDR) && wd[0];

  // Sticky press flag and counter; a press on the clearing edge is kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= 1'b0;
      press_cnt <= '0;
    end else if (btn_rise) begin
      pending   <= 1'b1;
      press_cnt <= press_cnt + 1'b1;
    end else if (clr_req) begin
      pending <= 1'b0;
    end
  end

  // Read decode; reads never disturb state.
  always_comb begin
    rd  = 32'b0;
    hit = 1'b0;
    if (a == SW_ADDR) begin
      rd  = 32'(sw_p1);
      hit = 1'b1;
    end else if (a == BTN_ADDR) begin
      rd  = btn_status_word(press_cnt, btn_level, pending);
      hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_input_capture.sv
// Randomized and directed bench for mmio_input_capture against a
// behavioural reference model built from the acceptance-window rule.
module tb_mmio_input_capture;

  localparam int          D      = 4;
  localparam int          NSW    = 10;
  localparam logic [31:0] A_SW   = 32'hC000_0004;
  localparam logic [31:0] A_BTN  = 32'hC000_0010;
  localparam int          HMAX   = 65536;

  logic           clk = 1'b0;
  logic           reset;
  logic           btn_raw;
  logic [NSW-1:0] sw_raw;
  logic [31:0]    a;
  logic           we;
  logic [31:0]    wd;
  logic [31:0]    rd;
  logic           hit;

  int n_vec = 0;
  int n_bad = 0;

  mmio_input_capture #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (1'b1),
    .NSW            (NSW),
    .SW_ADDR        (A_SW),
    .BTN_ADDR       (A_BTN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .sw_raw (sw_raw),
    .a      (a),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .hit    (hit)
  );

  always #5 clk = ~clk;

  // Reference model: s2h[n] is the synchronized pressed level after edge n.
  // A change is accepted at edge n when the D synchronized samples before it
  // all disagree with the current level and none predate the last reset.
  bit             s2h [0:HMAX-1];
  int             n_edge   = 0;
  int             last_rst = 0;
  logic           m_s1     = 1'b0;
  logic           m_st     = 1'b0;
  logic           m_pend   = 1'b0;
  logic [7:0]     m_cnt    = 8'd0;
  logic [NSW-1:0] m_sw1    = '0;
  logic [NSW-1:0] m_sw2    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] addr);
    if (addr == A_SW)  return {22'b0, m_sw2};
    if (addr == A_BTN) return {16'b0, m_cnt, 6'b0, m_st, m_pend};
    return 32'b0;
  endfunction

  task automatic model_edge();
    bit acc;
    bit press;
    bit clr;
    if (n_edge >= HMAX) begin
      $display("FAIL model_hist: edge index %0d exceeds %0d", n_edge, HMAX);
      $fatal(1, "history overflow");
    end
    if (!reset) begin
      m_s1 = 1'b0; m_st = 1'b0; m_pend = 1'b0; m_cnt = 8'd0;
      m_sw1 = '0; m_sw2 = '0;
      s2h[n_edge] = 1'b0;
      last_rst = n_edge;
    end else begin
      acc = (n_edge - D >= last_rst);
      if (acc)
        for (int j = 1; j <= D; j++)
          if (s2h[n_edge - j] == m_st) acc = 1'b0;
      press = acc && !m_st;
      clr   = we && (a == A_BTN) && wd[0];
      if (acc) m_st = ~m_st;
      if (press) begin
        m_pend = 1'b1;
        m_cnt  = m_cnt + 8'd1;
      end else if (clr) begin
        m_pend = 1'b0;
      end
      s2h[n_edge] = m_s1;
      m_s1  = ~btn_raw;
      m_sw2 = m_sw1;
      m_sw1 = sw_raw;
    end
    n_edge++;
  endtask

  // One clock: update the model at the edge, then compare shortly after.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_model", rd, m_rd(a));
    chk("hit_model", 32'(hit), 32'((a == A_SW) || (a == A_BTN)));
  endtask

  task automatic press_release();
    btn_raw = 1'b0;
    repeat (D + 4) tick();
    btn_raw = 1'b1;
    repeat (D + 4) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; btn_raw = 1'b1; sw_raw = '0; a = A_BTN; we = 1'b0; wd = '0;

    // Reset state and decode.
    repeat (2) tick();
    chk("rst_btn_rd", rd, 32'h0);
    chk("rst_btn_hit", 32'(hit), 32'h1);
    a = 32'h20; #1;
    chk("rst_other_hit", 32'(hit), 32'h0);
    chk("rst_other_rd", rd, 32'h0);
    a = A_BTN;
    reset = 1'b1;
    repeat (6) tick();

    // Press latency: accepted on the sixth edge after the pin changes.
    btn_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("lat_hold", 32'(rd[1:0]), 32'h0);
    end
    tick();
    chk("lat_accept", rd, 32'h0000_0103);

    // Release, clear, then a short bounce that must be rejected.
    btn_raw = 1'b1;
    repeat (D + 4) tick();
    chk("release", rd, 32'h0000_0101);
    we = 1'b1; wd = 32'h1; tick(); we = 1'b0;
    chk("clear", rd, 32'h0000_0100);
    btn_raw = 1'b0;
    repeat (3) tick();
    btn_raw = 1'b1;
    repeat (10) tick();
    chk("bounce", rd, 32'h0000_0100);

    // wd[0]=0 write has no effect; wd[0]=1 clears.
    btn_raw = 1'b0;
    repeat (D + 4) tick();
    chk("press2", rd, 32'h0000_0203);
    we = 1'b1; wd = 32'hFFFF_FFFE; tick();
    chk("wd0_noclr", 32'(rd[0]), 32'h1);
    wd = 32'h0000_0001; tick(); we = 1'b0;
    chk("wd1_clr", rd, 32'h0000_0202);
    btn_raw = 1'b1;
    repeat (D + 4) tick();

    // Clear on the same edge as an accepted press: set wins.
    btn_raw = 1'b0;
    repeat (5) tick();
    we = 1'b1; wd = 32'h1; tick(); we = 1'b0;
    chk("set_wins", rd, 32'h0000_0303);
    btn_raw = 1'b1;
    repeat (D + 4) tick();

    // Switch synchronizer latency.
    a = A_SW; sw_raw = 10'h2A5;
    tick();
    chk("sw_edge1", rd, 32'h0);
    tick();
    chk("sw_edge2", rd, 32'h0000_02A5);
    a = A_BTN;

    // Counter wrap after 256 presses from reset.
    do_reset();
    repeat (4) tick();
    for (int i = 0; i < 255; i++) press_release();
    chk("cnt_255", rd, 32'h0000_FF01);
    press_release();
    chk("cnt_wrap", rd, 32'h0000_0001);

    // Button held through a reset is a new press D+2 edges after release.
    btn_raw = 1'b0;
    repeat (3) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 1; i <= D + 1; i++) begin
      tick();
      chk("rstmid_hold", 32'(rd[1:0]), 32'h0);
    end
    tick();
    chk("rstmid_accept", rd, 32'h0000_0103);
    btn_raw = 1'b1;
    repeat (D + 4) tick();

    // Randomized traffic checked every cycle against the model.
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      btn_raw = 1'($urandom);
      hold = $urandom_range(1, 2 * D + 2);
      for (int k = 0; k < hold; k++) begin
        case ($urandom_range(0, 3))
          0: a = A_SW;
          1: a = A_BTN;
          2: a = 32'hC000_0008;
          default: a = $urandom;
        endcase
        we = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) a = we ? A_BTN : a;
        wd = $urandom;
        if ($urandom_range(0, 7) == 0) sw_raw = NSW'($urandom);
        reset = ($urandom_range(0, 249) != 0);
        tick();
      end
    end
    reset = 1'b1; we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
